shifter_seq: RTL
================

// Module: shifter_seq
// PURPOSE
//  Parametrised multi-cycle shifter; successor to the 1-bit combinational datapath shifter.
//  Shifts a WIDTH-bit operand by 0..WIDTH-1 positions, STEP bits per cycle, in one of four modes (LSL/LSR/ASR/ROR).
//  Sits between register-file read and ALU B-input; valid/ready on both sides so the controller can stall it.
// PARAMETERS
//  WIDTH  16  operand width in bits; >=2; AMT_W = $clog2(WIDTH)
//  STEP   1   max bit positions shifted per BUSY cycle; 1..WIDTH-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request
//  in_data    in   WIDTH  operand
//  in_amt     in   AMT_W  shift amount
//  in_mode    in   2      00 LSL, 01 LSR, 10 ASR (sign-fill), 11 ROR
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result
//  out_data   out  WIDTH  shifted result
//  out_carry  out  1      last bit shifted out (SHIFTER_CARRY_EN only)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, cnt=0.
//  - FSM: IDLE -> BUSY on accept (in_valid & in_ready) with in_amt!=0; IDLE -> DONE on accept with in_amt==0.
//    BUSY: each edge shifts by s=min(STEP,cnt), cnt-=s; -> DONE on the edge where cnt reaches 0.
//    DONE: out_valid=1; -> IDLE on out_valid & out_ready.
//  - in_ready=1 only in IDLE. No accept in DONE, even when out_ready=1 on the same cycle; back-to-back issue costs one IDLE cycle.
//  - Latency: accept at edge k -> out_valid high after edge k+ceil(amt/STEP); amt==0 -> high after edge k with data unchanged.
//  - Per step: LSL fills 0 at LSB; LSR fills 0 at MSB; ASR fills the captured MSB; ROR wraps LSBs into MSBs.
//    Result equals the single-shot shift by amt for every STEP value.
//  - out_data and out_carry hold stable while out_valid & !out_ready. Inputs are sampled only at accept.
//  - in_amt >= WIDTH cannot occur (AMT_W bits); ROR by k is modulo WIDTH by construction.
//  - rst_n low mid-operation aborts the operation; the result is discarded and the reset values apply immediately.
// CONFIGURATION
//  - SHIFTER_CARRY_EN defined: out_carry = last bit shifted out (LSL: bit WIDTH-amt of the input;
//    LSR/ASR/ROR: bit amt-1). Forced 0 when amt==0. Updated every BUSY step; valid while out_valid.
//  - SHIFTER_CARRY_EN undefined: out_carry port still present, tied 0; carry register not instantiated.
// STRUCTURE
//  - shifter_pkg: mode localparams SH_LSL/SH_LSR/SH_ASR/SH_ROR (2'b00..2'b11); state encoding S_IDLE/S_BUSY/S_DONE.
//  - Sub-module shifter_step: combinational; inputs data, mode, s (0..STEP); outputs shifted data and carry.
//    One instance per shifter_seq. shifter_seq owns the FSM, cnt and the data/carry registers.
// TESTING (WIDTH=16, STEP=1 unless stated; out_ready=1 unless stated)
//  1. LSL amt=1, 0xA455 -> 0x48AA after 1 cycle; carry=1.
//     ASR amt=1, 0x810F -> 0xC087; carry=1.
//     LSR amt=1, 0x5555 -> 0x2AAA; carry=1.
//  2. ROR amt=4, 0x1234 -> 0x4123; out_valid exactly 4 cycles after accept; in_ready=0 throughout.
//     Repeat with STEP=3: same data, 2 cycles.
//  3. LSR amt=15, 0x8000 -> 0x0001.
//     ASR amt=15, 0x8000 -> 0xFFFF.
//     amt=0, 0xBEEF, any mode -> 0xBEEF after 1 cycle; carry=0.
//  4. Backpressure: LSL amt=2, 0x0003, out_ready=0 for 5 cycles -> out_data=0x000C held stable;
//     in_valid pulses ignored; accept resumes one cycle after the handshake.
//  5. Reset mid-op: ROR amt=10, rst_n low at cycle 3 -> immediately out_valid=0, in_ready=1, out_data=0;
//     next request completes correctly.
//  6. Random mode/amt/data (>=1000), STEP in {1,2,5}: compare to a reference model.
//     Run with and without SHIFTER_CARRY_EN; without it, out_carry is always 0.

Source files
------------

// File: rtl/shifter_pkg.sv
// shifter_pkg: mode codes and FSM state encoding shared by
// shifter_seq, shifter_step and their bench.
package shifter_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shifter_step.sv
// shifter_step: one combinational shift of i_data by i_s (0..STEP)
// positions in mode i_mode; o_carry is the last bit shifted out.
// Ports: i_data/i_mode/i_s in, o_data/o_carry out.
module shifter_step
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  STEP  = 1,
  localparam int SW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [1:0]       i_mode,
  input  logic [SW-1:0]    i_s,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry
);

  // One guard bit beside the operand catches the last bit out.
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic [WIDTH:0]   w_asr;
  logic [WIDTH-1:0] w_ror;

  always_comb begin
    w_lsl = {1'b0, i_data} << i_s;
    w_lsr = {i_data, 1'b0} >> i_s;
    w_asr = $signed({i_data, 1'b0}) >>> i_s;
    // i_s == 0 makes the left term a full-width shift, i.e. zero.
    w_ror = (i_data >> i_s)
          | (i_data << (WIDTH - int'(i_s)));
    o_data  = w_lsl[WIDTH-1:0];
    o_carry = w_lsl[WIDTH];
    unique case (i_mode)
      SH_LSL: begin
        o_data  = w_lsl[WIDTH-1:0];
        o_carry = w_lsl[WIDTH];
      end
      SH_LSR: begin
        o_data  = w_lsr[WIDTH:1];
        o_carry = w_lsr[0];
      end
      SH_ASR: begin
        o_data  = w_asr[WIDTH:1];
        o_carry = w_asr[0];
      end
      SH_ROR: begin
        o_data  = w_ror;
        o_carry = w_lsr[0];
      end
    endcase
  end

endmodule

// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle LSL/LSR/ASR/ROR shifter, STEP bits/cycle,
// valid/ready on both sides. Optional carry: SHIFTER_CARRY_EN.
// Ports: clk, rst_n, in_valid/in_ready/in_data/in_amt/in_mode,
//        out_valid/out_ready/out_data/out_carry.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  STEP  = 1,
  localparam int AMT_W = $clog2(WIDTH),
  localparam int SW    = $clog2(STEP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry
);

  state_t           r_state;
  state_t           w_next;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_mode;
  logic [SW-1:0]    w_s;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;
  logic             w_accept;
  logic             w_busy;
  logic             w_last;

  // s = min(STEP, cnt)
  always_comb begin
    w_s = SW'(STEP);
    if (int'(r_cnt) < STEP) w_s = SW'(r_cnt);
  end

  assign w_accept = in_valid & in_ready;
  assign w_busy   = (r_state == S_BUSY);
  assign w_last   = (r_cnt == AMT_W'(w_s));
  assign out_data = r_data;

  shifter_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .i_data  (r_data),
    .i_mode  (r_mode),
    .i_s     (w_s),
    .o_data  (w_step_data),
    .o_carry (w_step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (in_amt == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_mode <= SH_LSL;
    end else if (w_accept) begin
      r_cnt  <= in_amt;
      r_data <= in_data;
      r_mode <= in_mode;
    end else if (w_busy) begin
      r_cnt  <= r_cnt - AMT_W'(w_s);
      r_data <= w_step_data;
    end
  end

`ifdef SHIFTER_CARRY_EN
  logic r_carry;

  // Cleared on accept so amt == 0 reports no carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_carry <= 1'b0;
    else if (w_accept) r_carry <= 1'b0;
    else if (w_busy)   r_carry <= w_step_carry;
  end

  assign out_carry = r_carry;
`else
  logic w_unused_carry;

  assign w_unused_carry = w_step_carry;
  assign out_carry      = 1'b0;
`endif

endmodule
